// File: rtl/pred_pkg.sv
// Shared definitions for the predictor FMULT/ACCUM sequencer.
// Holds the sequencer state encoding, default term counts, the ACCUM width,
// and the operand-pair index constants used by the operand muxes.
package pred_pkg;

   // Default sizing
   localparam int unsigned NZ_DEF      = 6;   // zero-section (B) terms
   localparam int unsigned NP_DEF      = 2;   // pole-section (A) terms
   localparam int unsigned AW_DEF      = 16;  // ACCUM width
   localparam int unsigned TIMEOUT_DEF = 64;  // WAIT cycles per term before abort

   // Index and state widths
   localparam int unsigned IW = 3;
   localparam int unsigned SW = 3;

   // Operand-pair index constants
   localparam logic [IW-1:0] IDX_B1 = IW'(0);
   localparam logic [IW-1:0] IDX_A1 = IW'(NZ_DEF);

   // Sequencer state encoding
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] CLEAR = 3'd1;
   localparam logic [2:0] MUL   = 3'd2;
   localparam logic [2:0] WAIT  = 3'd3;
   localparam logic [2:0] ADD   = 3'd4;
   localparam logic [2:0] CAPZ  = 3'd5;
   localparam logic [2:0] CAPE  = 3'd6;
   localparam logic [2:0] DONE  = 3'd7;

endpackage

// File: rtl/seq_watchdog.sv
// Per-term WAIT watchdog for the FMULT/ACCUM sequencer.
// Ports:
//   clk     in  system clock, rising edge
//   reset   in  asynchronous active-low reset
//   clr     in  restart the count at zero (issued when a product is launched)
//   en      in  advance the count by one (each WAIT cycle without fm_done)
//   expire  out count has reached TIMEOUT-1
module seq_watchdog #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] cnt;

   // Cycle counter; holds at the terminal value so it can never wrap
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !expire) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign expire = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/accum_seq_ctrl.sv
// Per-channel sequencer for the predictor's shared FMULT/ACCUM resource.
// On start it clears ACCUM, then launches NZ zero-section products
// (B x DQ) and NP pole-section products (A x SR), gating each result into
// ACCUM. SEZ is captured after the last zero term, SE after the last pole term.
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   start      in   begin one channel (sampled only in IDLE)
//   fm_done    in   FMULT result valid (sampled only in WAIT)
//   S          in   ACCUM register output, AW bits two's complement
//   fm_start   out  launch FMULT on operand pair idx (state decode)
//   idx        out  operand-pair select 0..NZ+NP-1
//   acc_clear  out  ACCUM clear (state decode)
//   acc_add    out  W gate into ACCUM (state decode)
//   sez        out  S[AW-1:1] after the last zero term
//   se         out  S[AW-1:1] after the last pole term
//   busy       out  high in every state but IDLE
//   done       out  one-cycle end-of-channel pulse (normal or abort)
//   err        out  sticky timeout flag, cleared by an accepted start
module accum_seq_ctrl
   import pred_pkg::*;
#(
   parameter int unsigned NZ      = NZ_DEF,
   parameter int unsigned NP      = NP_DEF,
   parameter int unsigned AW      = AW_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          fm_done,
   input  logic [AW-1:0] S,
   output logic          fm_start,
   output logic [IW-1:0] idx,
   output logic          acc_clear,
   output logic          acc_add,
   output logic [AW-2:0] sez,
   output logic [AW-2:0] se,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam logic [IW-1:0] IDX_ZLAST = IW'(NZ - 1);
   localparam logic [IW-1:0] IDX_PLAST = IW'(NZ + NP - 1);

   logic [SW-1:0] state;
   logic [SW-1:0] state_next;
   logic [IW-1:0] idx_next;
   logic [AW-2:0] sez_next;
   logic [AW-2:0] se_next;
   logic          err_next;
   logic          wd_clr;
   logic          wd_en;
   logic          wd_expire;
   logic          unused_s_lsb;

   // The halved captures drop the ACCUM LSB
   assign unused_s_lsb = S[0];

   // WAIT timeout counter
   seq_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk    (clk),
      .reset  (reset),
      .clr    (wd_clr),
      .en     (wd_en),
      .expire (wd_expire)
   );

   // Next-state, index and capture logic
   always_comb begin
      state_next = state;
      idx_next   = idx;
      sez_next   = sez;
      se_next    = se;
      err_next   = err;
      wd_clr     = 1'b0;
      wd_en      = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               state_next = CLEAR;
               err_next   = 1'b0;
               idx_next   = IDX_B1;
            end
         end
         CLEAR: begin
            state_next = MUL;
         end
         MUL: begin
            state_next = WAIT;
            wd_clr     = 1'b1;
         end
         WAIT: begin
            // A result arriving on the expiry cycle still counts
            if (fm_done) begin
               state_next = ADD;
            end else if (wd_expire) begin
               err_next   = 1'b1;
               state_next = DONE;
            end else begin
               wd_en = 1'b1;
            end
         end
         ADD: begin
            if (idx == IDX_ZLAST) begin
               state_next = CAPZ;
            end else if (idx == IDX_PLAST) begin
               state_next = CAPE;
            end else begin
               idx_next   = idx + IW'(1);
               state_next = MUL;
            end
         end
         CAPZ: begin
            sez_next   = S[AW-1:1];
            idx_next   = idx + IW'(1);
            state_next = MUL;
         end
         CAPE: begin
            se_next    = S[AW-1:1];
            state_next = DONE;
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and output registers; busy/done follow the state being entered
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         idx   <= '0;
         sez   <= '0;
         se    <= '0;
         err   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         idx   <= idx_next;
         sez   <= sez_next;
         se    <= se_next;
         err   <= err_next;
         busy  <= (state_next != IDLE);
         done  <= (state_next == DONE);
      end
   end

   // Datapath strobes decoded from the state register
   assign acc_clear = (state == CLEAR);
   assign fm_start  = (state == MUL);
   assign acc_add   = (state == ADD);

endmodule

// File: tb/tb_accum_seq_ctrl.sv
// Bench for accum_seq_ctrl: behavioural FMULT with per-term latency plus an
// ACCUM model gated by acc_add; expectations come from plain sums of the
// per-term products and latencies.
`timescale 1ns/1ps
module tb_accum_seq_ctrl;

   localparam int unsigned AW      = 16;
   localparam int unsigned NT      = 8;
   localparam int unsigned NZ      = 6;
   localparam int          TIMEOUT = 64;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          fm_done;
   logic [AW-1:0] S;
   logic          fm_start;
   logic [2:0]    idx;
   logic          acc_clear;
   logic          acc_add;
   logic [AW-2:0] sez;
   logic [AW-2:0] se;
   logic          busy;
   logic          done;
   logic          err;

   int checks   = 0;
   int failures = 0;

   logic [AW-1:0] prod  [NT];
   int            k_arr [NT];
   bit            no_resp = 1'b0;
   bit            spur_en = 1'b0;

   logic          fm_done_m;
   logic [AW-1:0] w_reg;
   int            rem;
   bit            pend;

   accum_seq_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .fm_done   (fm_done),
      .S         (S),
      .fm_start  (fm_start),
      .idx       (idx),
      .acc_clear (acc_clear),
      .acc_add   (acc_add),
      .sez       (sez),
      .se        (se),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Spurious fm_done pulses land only outside WAIT
   assign fm_done = fm_done_m | (spur_en & (fm_start | acc_add | acc_clear));

   // Behavioural FMULT (latency k per term) and ACCUM
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         fm_done_m <= 1'b0;
         pend      <= 1'b0;
         rem       <= 0;
         w_reg     <= '0;
         S         <= '0;
      end else begin
         fm_done_m <= 1'b0;
         if (fm_start && !no_resp) begin
            if (k_arr[idx] <= 1) begin
               fm_done_m <= 1'b1;
               w_reg     <= prod[idx];
               pend      <= 1'b0;
            end else begin
               pend <= 1'b1;
               rem  <= k_arr[idx] - 1;
            end
         end else if (pend) begin
            if (rem == 1) begin
               fm_done_m <= 1'b1;
               w_reg     <= prod[idx];
               pend      <= 1'b0;
            end else begin
               rem <= rem - 1;
            end
         end
         if (acc_clear)    S <= '0;
         else if (acc_add) S <= S + w_reg;
      end
   end

   // Golden capture: sum of products 0..last modulo 2^AW, arithmetic >>1
   function automatic logic [AW-2:0] exp_cap(input int last);
      logic [AW-1:0] acc = '0;
      for (int i = 0; i <= last; i++) acc = acc + prod[i];
      return acc[AW-1:1];
   endfunction

   // Golden done cycle: CLEAR + CAPZ + CAPE plus (MUL + k WAIT + ADD) per term
   function automatic int exp_cycles();
      int c = 3;
      for (int i = 0; i < NT; i++) c += k_arr[i] + 2;
      return c;
   endfunction

   task automatic set_prod(input logic [AW-1:0] b, input logic [AW-1:0] a, input int k);
      for (int i = 0; i < NT; i++) begin
         prod[i]  = (i < NZ) ? b : a;
         k_arr[i] = k;
      end
   endtask

   // Launch one channel from IDLE; cycle 0 is the cycle after the start-sampling edge
   task automatic run_channel(input bit abuse, input int max_cyc, output int done_cyc,
                              output int ndone, output logic clr0, output logic err0,
                              output int max_idx);
      int n;
      done_cyc = -1;
      ndone    = 0;
      max_idx  = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      clr0 = acc_clear;
      err0 = err;
      n = 0;
      while (n <= max_cyc && (done_cyc < 0 || n <= done_cyc + 3)) begin
         if (done === 1'b1) begin
            ndone++;
            if (done_cyc < 0) done_cyc = n;
         end
         if (int'(idx) > max_idx) max_idx = int'(idx);
         if (abuse) start = (n < 20) ? 1'($urandom_range(1, 0)) : 1'b0;
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      start = 1'b0;
      set_prod(16'h0010, 16'h0010, 1);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({fm_start, acc_clear, acc_add, busy, done, err} !== 6'b0) begin
         failures++;
         $display("FAIL reset_ctrl: got %b want 000000", {fm_start, acc_clear, acc_add, busy, done, err});
      end
      checks++;
      if (idx !== 3'd0) begin
         failures++;
         $display("FAIL reset_idx: got %0d want 0", idx);
      end
      checks++;
      if (sez !== '0 || se !== '0) begin
         failures++;
         $display("FAIL reset_caps: got sez=%h se=%h want 0", sez, se);
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_release_idle: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_positive();
      int dc, nd, mi;
      logic c0, e0;
      set_prod(16'h0010, 16'h0010, 1);
      run_channel(1'b0, 200, dc, nd, c0, e0, mi);
      checks++;
      if (c0 !== 1'b1) begin
         failures++;
         $display("FAIL pos_clear_first: got acc_clear=%b want 1", c0);
      end
      checks++;
      if (dc !== 27) begin
         failures++;
         $display("FAIL pos_done_cycle: got %0d want 27", dc);
      end
      checks++;
      if (nd !== 1) begin
         failures++;
         $display("FAIL pos_done_count: got %0d want 1", nd);
      end
      checks++;
      if (sez !== 15'h0030) begin
         failures++;
         $display("FAIL pos_sez: got %h want 0030", sez);
      end
      checks++;
      if (se !== 15'h0040) begin
         failures++;
         $display("FAIL pos_se: got %h want 0040", se);
      end
      checks++;
      if (err !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL pos_err_busy: got err=%b busy=%b want 0 0", err, busy);
      end
      checks++;
      if (mi !== 7) begin
         failures++;
         $display("FAIL pos_max_idx: got %0d want 7", mi);
      end
   endtask

   task automatic test_negative();
      int dc, nd, mi;
      logic c0, e0;
      set_prod(16'hFFF0, 16'hFFE0, 1);
      run_channel(1'b0, 200, dc, nd, c0, e0, mi);
      checks++;
      if (dc !== 27) begin
         failures++;
         $display("FAIL neg_done_cycle: got %0d want 27", dc);
      end
      checks++;
      if (sez !== 15'h7FD0) begin
         failures++;
         $display("FAIL neg_sez: got %h want 7fd0", sez);
      end
      checks++;
      if (se !== 15'h7FB0) begin
         failures++;
         $display("FAIL neg_se: got %h want 7fb0", se);
      end
   endtask

   task automatic test_abuse();
      int dc, nd, mi;
      logic c0, e0;
      set_prod(16'h0010, 16'h0010, 1);
      spur_en = 1'b1;
      run_channel(1'b1, 200, dc, nd, c0, e0, mi);
      spur_en = 1'b0;
      checks++;
      if (nd !== 1) begin
         failures++;
         $display("FAIL abuse_done_count: got %0d want 1", nd);
      end
      checks++;
      if (dc !== 27) begin
         failures++;
         $display("FAIL abuse_done_cycle: got %0d want 27", dc);
      end
      checks++;
      if (sez !== 15'h0030 || se !== 15'h0040) begin
         failures++;
         $display("FAIL abuse_caps: got sez=%h se=%h want 0030 0040", sez, se);
      end
   endtask

   task automatic test_timeout();
      int dc, nd, mi;
      logic c0, e0;
      no_resp = 1'b1;
      run_channel(1'b0, 200, dc, nd, c0, e0, mi);
      no_resp = 1'b0;
      checks++;
      if (dc !== 2 + TIMEOUT) begin
         failures++;
         $display("FAIL to_done_cycle: got %0d want %0d", dc, 2 + TIMEOUT);
      end
      checks++;
      if (nd !== 1) begin
         failures++;
         $display("FAIL to_done_count: got %0d want 1", nd);
      end
      checks++;
      if (err !== 1'b1) begin
         failures++;
         $display("FAIL to_err_sticky: got %b want 1", err);
      end
      checks++;
      if (sez !== 15'h0030 || se !== 15'h0040) begin
         failures++;
         $display("FAIL to_caps_kept: got sez=%h se=%h want 0030 0040", sez, se);
      end
      set_prod(16'hFFF0, 16'hFFE0, 1);
      run_channel(1'b0, 200, dc, nd, c0, e0, mi);
      checks++;
      if (e0 !== 1'b0) begin
         failures++;
         $display("FAIL to_err_cleared: got %b want 0", e0);
      end
      checks++;
      if (dc !== 27 || sez !== 15'h7FD0 || se !== 15'h7FB0) begin
         failures++;
         $display("FAIL to_recover: got cyc=%0d sez=%h se=%h want 27 7fd0 7fb0", dc, sez, se);
      end
   endtask

   task automatic test_reset_mid();
      int dc, nd, mi;
      logic c0, e0;
      bit found;
      set_prod(16'h0010, 16'h0010, 1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 100 && !found; n++) begin
         if (fm_start === 1'b1 && idx === 3'd3) found = 1'b1;
         @(posedge clk); #1;
      end
      checks++;
      if (!found || busy !== 1'b1) begin
         failures++;
         $display("FAIL rmid_reach_wait3: got found=%b busy=%b want 1 1", found, busy);
      end
      #1;
      reset = 1'b0;
      #1;
      checks++;
      if ({fm_start, acc_clear, acc_add, busy, done, err} !== 6'b0 || idx !== 3'd0) begin
         failures++;
         $display("FAIL rmid_ctrl_zero: got %b idx=%0d want 000000 idx=0",
                  {fm_start, acc_clear, acc_add, busy, done, err}, idx);
      end
      checks++;
      if (sez !== '0 || se !== '0) begin
         failures++;
         $display("FAIL rmid_caps_zero: got sez=%h se=%h want 0", sez, se);
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      run_channel(1'b0, 200, dc, nd, c0, e0, mi);
      checks++;
      if (dc !== 27 || sez !== 15'h0030 || se !== 15'h0040) begin
         failures++;
         $display("FAIL rmid_fresh: got cyc=%0d sez=%h se=%h want 27 0030 0040", dc, sez, se);
      end
   endtask

   task automatic test_var_latency();
      int dc, nd, mi;
      logic c0, e0;
      for (int it = 0; it < 5; it++) begin
         for (int i = 0; i < NT; i++) begin
            prod[i]  = AW'($urandom);
            k_arr[i] = int'($urandom_range(5, 1));
         end
         run_channel(1'b0, 200, dc, nd, c0, e0, mi);
         checks++;
         if (dc !== exp_cycles()) begin
            failures++;
            $display("FAIL var_done_cycle[%0d]: got %0d want %0d", it, dc, exp_cycles());
         end
         checks++;
         if (sez !== exp_cap(NZ - 1)) begin
            failures++;
            $display("FAIL var_sez[%0d]: got %h want %h", it, sez, exp_cap(NZ - 1));
         end
         checks++;
         if (se !== exp_cap(NT - 1)) begin
            failures++;
            $display("FAIL var_se[%0d]: got %h want %h", it, se, exp_cap(NT - 1));
         end
         checks++;
         if (err !== 1'b0 || nd !== 1) begin
            failures++;
            $display("FAIL var_err_done[%0d]: got err=%b ndone=%0d want 0 1", it, err, nd);
         end
      end
   endtask

   task automatic test_start_held();
      int n, d;
      set_prod(16'h0010, 16'h0010, 1);
      start = 1'b1;
      @(posedge clk); #1;
      n = 0;
      d = -1;
      while (n < 200 && d < 0) begin
         if (done === 1'b1) d = n;
         else begin
            @(posedge clk); #1;
            n++;
         end
      end
      checks++;
      if (d !== 27) begin
         failures++;
         $display("FAIL held_done_cycle: got %0d want 27", d);
      end
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || acc_clear !== 1'b0) begin
         failures++;
         $display("FAIL held_idle_gap: got busy=%b acc_clear=%b want 0 0", busy, acc_clear);
      end
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (acc_clear !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL held_rearm: got acc_clear=%b busy=%b want 1 1", acc_clear, busy);
      end
      n = 0;
      d = -1;
      while (n < 200 && d < 0) begin
         if (done === 1'b1) d = n;
         else begin
            @(posedge clk); #1;
            n++;
         end
      end
      checks++;
      if (d !== 27 || sez !== 15'h0030 || se !== 15'h0040) begin
         failures++;
         $display("FAIL held_second: got cyc=%0d sez=%h se=%h want 27 0030 0040", d, sez, se);
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_positive();
      test_negative();
      test_abuse();
      test_timeout();
      test_reset_mid();
      test_var_latency();
      test_start_held();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard stop if the run ever stalls
   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
